// File: rtl/hsp_pkg.sv
// Shared constants for the HSP FIFO drain path: field geometry, packed-word
// offsets, state encoding and the header magic byte.
package hsp_pkg;

   localparam int unsigned FIELD_W   = 8;
   localparam int unsigned WORD_W    = 4 * FIELD_W;

   // Field placement inside the packed host word {score, l, q, s}
   localparam int unsigned S_LSB     = 0;
   localparam int unsigned Q_LSB     = FIELD_W;
   localparam int unsigned L_LSB     = 2 * FIELD_W;
   localparam int unsigned SCORE_LSB = 3 * FIELD_W;

   // Wide enough for a packet length of up to 16 entries
   localparam int unsigned LEN_W     = 5;

   // Drain state encoding (kept as plain constants for legacy tooling)
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_HDR   = 2'd1;
   localparam logic [1:0] ST_READ  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   localparam logic [7:0] HDR_MAGIC = 8'hA5;

endpackage

// File: rtl/hsp_skid2.sv
// Two-entry valid/ready skid buffer. Carries the data word only; framing
// is derived by the instantiating block. The head entry drives rd_data.
module hsp_skid2 #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr,
   input  logic [W-1:0] wr_data,
   input  logic         rd,
   output logic [W-1:0] rd_data,
   output logic [1:0]   occ
);

   logic [W-1:0] e0;
   logic [W-1:0] e1;
   logic         pop;

   assign pop     = rd && (occ != 2'd0);
   assign rd_data = e0;

   // Entry storage and occupancy; simultaneous write and pop keeps occ
   always_ff @(posedge clk) begin
      if (!rst) begin
         e0  <= '0;
         e1  <= '0;
         occ <= '0;
      end else begin
         case ({wr, pop})
            2'b10: begin
               if (occ == 2'd0) e0 <= wr_data;
               else             e1 <= wr_data;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               e0  <= e1;
               occ <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  e0 <= wr_data;
               end else begin
                  e0 <= e1;
                  e1 <= wr_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/hsp_fifo_drain.sv
// Read-side master for the HSP FIFO: pops entries, packs {score,l,q,s}
// into one word and emits framed valid/ready packets towards the DMA path.
// Optional macro HSP_FIFO_DRAIN_HEADER_EN prepends one header word per
// packet: {A5, 00, pkt_count[7:0], len[7:0]}.
module hsp_fifo_drain #(
   parameter int unsigned FIELD_W   = 8,
   parameter int unsigned CNT_W     = 5,
   parameter int unsigned BURST_LEN = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 fifo_rd_en,
   input  logic                 fifo_empty,
   input  logic [CNT_W-1:0]     fifo_count,
   input  logic [FIELD_W-1:0]   fifo_s,
   input  logic [FIELD_W-1:0]   fifo_q,
   input  logic [FIELD_W-1:0]   fifo_l,
   input  logic [FIELD_W-1:0]   fifo_score,
   input  logic                 flush,
   output logic [4*FIELD_W-1:0] st_data,
   output logic                 st_valid,
   input  logic                 st_ready,
   output logic                 st_sop,
   output logic                 st_eop,
   output logic                 busy,
   output logic [15:0]          pkt_count
);

   import hsp_pkg::*;

   localparam int unsigned W = 4 * FIELD_W;

   logic [1:0]       state;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] pops_left;
   logic [LEN_W-1:0] sent;
   logic [LEN_W-1:0] last_idx;
   logic [LEN_W-1:0] len_next;
   logic             inflight;
   logic [1:0]       occ;
   logic [2:0]       pend;
   logic [31:0]      cnt_ext;
   logic             start;
   logic             accept;
   logic             skid_wr;
   logic [W-1:0]     skid_wdata;
   logic [W-1:0]     entry_word;

   // Packet start decision, pop gating and framing
   always_comb begin
      cnt_ext    = 32'(fifo_count);
      start      = (state == ST_IDLE) &&
                   ((cnt_ext >= BURST_LEN) || (flush && (cnt_ext != 32'd0)));
      len_next   = (cnt_ext >= BURST_LEN) ? LEN_W'(BURST_LEN) : LEN_W'(cnt_ext);
      pend       = 3'(occ) + 3'(inflight);
      fifo_rd_en = (state == ST_READ) && (pops_left != '0) && !fifo_empty &&
                   (pend < 3'd2);
      st_valid   = (occ != 2'd0);
      accept     = st_valid && st_ready;
      entry_word = {fifo_score, fifo_l, fifo_q, fifo_s};
`ifdef HSP_FIFO_DRAIN_HEADER_EN
      // Header occupies word 0, so the last data word sits at index len
      last_idx   = len;
      skid_wr    = inflight || (state == ST_HDR);
      skid_wdata = (state == ST_HDR) ?
                   W'({HDR_MAGIC, 8'h00, pkt_count[7:0], 3'b000, len}) :
                   entry_word;
`else
      last_idx   = len - LEN_W'(1);
      skid_wr    = inflight;
      skid_wdata = entry_word;
`endif
      st_sop     = st_valid && (sent == '0);
      st_eop     = st_valid && (sent == last_idx);
      busy       = (state != ST_IDLE);
   end

   // Control state, pop accounting and packet counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         len       <= '0;
         pops_left <= '0;
         sent      <= '0;
         inflight  <= 1'b0;
         pkt_count <= '0;
      end else begin
         inflight <= fifo_rd_en;
         if (accept) sent <= sent + LEN_W'(1);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  len       <= len_next;
                  pops_left <= len_next;
                  sent      <= '0;
`ifdef HSP_FIFO_DRAIN_HEADER_EN
                  state     <= ST_HDR;
`else
                  state     <= ST_READ;
`endif
               end
            end
            ST_HDR: state <= ST_READ;
            ST_READ: begin
               if (fifo_rd_en) begin
                  pops_left <= pops_left - LEN_W'(1);
                  if (pops_left == LEN_W'(1)) state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (accept && st_eop) begin
                  pkt_count <= pkt_count + 16'd1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   hsp_skid2 #(.W(W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .wr      (skid_wr),
      .wr_data (skid_wdata),
      .rd      (st_ready),
      .rd_data (st_data),
      .occ     (occ)
   );

endmodule

// File: tb/tb_hsp_fifo_drain.sv
// Directed bench for hsp_fifo_drain: FIFO model, word scoreboard with
// framing, pop-gating model and a vector table of packet scenarios.
module tb_hsp_fifo_drain;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_rd_en;
   logic        fifo_empty;
   logic [4:0]  fifo_count;
   logic [7:0]  fifo_s, fifo_q, fifo_l, fifo_score;
   logic        flush;
   logic [31:0] st_data;
   logic        st_valid, st_ready, st_sop, st_eop, busy;
   logic [15:0] pkt_count;

   always #5 clk = ~clk;

   hsp_fifo_drain #(.FIELD_W(8), .CNT_W(5), .BURST_LEN(8)) dut (
      .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty),
      .fifo_count(fifo_count), .fifo_s(fifo_s), .fifo_q(fifo_q),
      .fifo_l(fifo_l), .fifo_score(fifo_score), .flush(flush),
      .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
      .st_sop(st_sop), .st_eop(st_eop), .busy(busy), .pkt_count(pkt_count)
   );

`ifdef HSP_FIFO_DRAIN_HEADER_EN
   localparam int HOFF = 1;
   localparam int LAT  = 0;
`else
   localparam int HOFF = 0;
   localparam int LAT  = 2;
`endif

   typedef struct {
      int       n;
      bit       fl;
      bit [3:0] rp;
      int       base;
      int       exp_pops;
      int       exp_pkts;
      bit       do_rst;
   } vec_t;

   vec_t        vecs[6];
   logic [31:0] fq[$];
   logic [31:0] exp_w[$];
   int          errors = 0, checks = 0;
   int          idx, pops, occ_m, cyc, first_pop, first_valid, pkt_m;
   bit          infl_m, busy_prev;
   bit   [3:0]  rpat;
   logic [31:0] got0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h (cyc %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] entry(input int i, input int base);
      logic [7:0] s, q, l, sc;
      s  = 8'(i + base);
      q  = 8'(i + 16 + base);
      l  = 8'(i + 1 + base);
      sc = 8'(i + 32 + base);
      return {sc, l, q, s};
   endfunction

   task automatic sync_fifo_flags();
      fifo_count = 5'(fq.size());
      fifo_empty = (fq.size() == 0);
   endtask

   // One clock: sample before the edge, then update the FIFO model after it
   task automatic tick();
      bit rd, acc, push;
      #3;
      rd  = fifo_rd_en;
      acc = st_valid && st_ready;
      if (st_valid) begin
         if (first_valid < 0) first_valid = cyc;
         if (idx < exp_w.size()) begin
            check("data", st_data, exp_w[idx]);
            check("sop", 32'(st_sop), 32'(idx == 0));
            check("eop", 32'(st_eop), 32'(idx == exp_w.size() - 1));
            if (acc && idx == HOFF) got0 = st_data;
         end else begin
            check("extra_word", 32'(st_valid), 32'd0);
         end
      end else begin
         check("idle_sop", 32'(st_sop), 32'd0);
         check("idle_eop", 32'(st_eop), 32'd0);
      end
      if (rd) begin
         check("occ_rule", 32'(occ_m + int'(infl_m) < 2), 32'd1);
         pops++;
         if (first_pop < 0) first_pop = cyc;
      end
      push = infl_m;
`ifdef HSP_FIFO_DRAIN_HEADER_EN
      if (busy && !busy_prev) push = 1'b1;
`endif
      occ_m     = occ_m + int'(push) - int'(acc);
      infl_m    = rd;
      busy_prev = busy;
      if (acc) idx++;
      @(posedge clk);
      #1;
      cyc++;
      if (rd && fq.size() > 0) {fifo_score, fifo_l, fifo_q, fifo_s} = fq.pop_front();
      else {fifo_score, fifo_l, fifo_q, fifo_s} = '0;
      sync_fifo_flags();
      st_ready = rpat[cyc % 4];
   endtask

   task automatic load(input int n, input int base);
      exp_w.delete();
`ifdef HSP_FIFO_DRAIN_HEADER_EN
      exp_w.push_back({8'hA5, 8'h00, 8'(pkt_m), 8'(n)});
`endif
      for (int i = 0; i < n; i++) begin
         fq.push_back(entry(i, base));
         exp_w.push_back(entry(i, base));
      end
      sync_fifo_flags();
   endtask

   initial begin
      vecs[0] = '{n:8, fl:0, rp:4'b1111, base:'h00, exp_pops:8, exp_pkts:1, do_rst:0};
      vecs[1] = '{n:3, fl:1, rp:4'b1111, base:'h40, exp_pops:3, exp_pkts:2, do_rst:0};
      vecs[2] = '{n:8, fl:0, rp:4'b1001, base:'h50, exp_pops:8, exp_pkts:3, do_rst:0};
      vecs[3] = '{n:1, fl:1, rp:4'b1111, base:'h60, exp_pops:1, exp_pkts:4, do_rst:0};
      vecs[4] = '{n:2, fl:1, rp:4'b1111, base:'h70, exp_pops:2, exp_pkts:5, do_rst:0};
      vecs[5] = '{n:8, fl:0, rp:4'b1111, base:'h10, exp_pops:8, exp_pkts:1, do_rst:1};

      rst = 1'b0; flush = 1'b0; st_ready = 1'b0; rpat = 4'b0000;
      {fifo_score, fifo_l, fifo_q, fifo_s} = '0;
      sync_fifo_flags();
      idx = 0; pops = 0; occ_m = 0; infl_m = 0; busy_prev = 0; cyc = 0; pkt_m = 0;
      first_pop = -1; first_valid = -1; got0 = '0;
      tick();
      tick();
      check("rst_valid", 32'(st_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pkt_count", 32'(pkt_count), 32'd0);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      rst = 1'b1;
      tick();

      for (int v = 0; v < 6; v++) begin
         int budget;
         if (vecs[v].do_rst) begin
            // Interrupt a packet after four accepted words
            rpat = 4'b1111; st_ready = 1'b1;
            load(8, 'h80);
            idx = 0; budget = 0;
            while (idx < 4 && budget < 100) begin tick(); budget++; end
            check("rst_reach4", 32'(idx >= 4), 32'd1);
            rst = 1'b0;
            tick();
            check("mid_rst_valid", 32'(st_valid), 32'd0);
            check("mid_rst_busy", 32'(busy), 32'd0);
            check("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
            check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
            fq.delete();
            sync_fifo_flags();
            occ_m = 0; infl_m = 0; busy_prev = 0; pkt_m = 0;
            rst = 1'b1;
            tick();
         end
         load(vecs[v].n, vecs[v].base);
         rpat = vecs[v].rp;
         cyc = 0; idx = 0; pops = 0; first_pop = -1; first_valid = -1;
         st_ready = rpat[0];
         flush = vecs[v].fl;
         tick();
         flush = 1'b0;
         budget = 0;
         while (pkt_count != 16'(vecs[v].exp_pkts) && budget < 200) begin
            tick(); budget++;
         end
         check("timeout", 32'(budget < 200), 32'd1);
         for (int k = 0; k < 3; k++) tick();
         check("pkt_count", 32'(pkt_count), 32'(vecs[v].exp_pkts));
         check("words", 32'(idx), 32'(exp_w.size()));
         check("pops", 32'(pops), 32'(vecs[v].exp_pops));
         check("latency", 32'(first_valid - first_pop), 32'(LAT));
         check("busy_end", 32'(busy), 32'd0);
         check("fifo_left", 32'(fq.size()), 32'd0);
         if (v == 0) check("word0", got0, 32'h20011000);
         pkt_m++;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hsp_fifo_drain.md
Name: hsp_fifo_drain

Overview:
- Read-side master for the HSP FIFO. Pops high-scoring-pair entries (s, q, l, score; 8 bits each).
- Packs each entry into one 32-bit word.
- Emits the words as framed Avalon-ST packets (sop/eop, valid/ready) towards the PCIe DMA write path.
- Sits between the HSP FIFO read port and the host-bound streaming mux.

Parameters:
- FIELD_W, 8: width of each HSP field; word width = 4*FIELD_W.
- CNT_W, 5: width of the FIFO occupancy input.
- BURST_LEN, 8: maximum entries per packet, range 1..16.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- fifo_rd_en  out  1  pop request to the HSP FIFO.
- fifo_empty  in  1  FIFO empty flag.
- fifo_count  in  CNT_W  FIFO occupancy.
- fifo_s, fifo_q, fifo_l, fifo_score  in  FIELD_W each  popped entry; valid exactly one cycle after a pop; zero otherwise.
- flush  in  1  level request: send a partial packet.
- st_data  out  4*FIELD_W  packed word {score,l,q,s}; score in [31:24], s in [7:0].
- st_valid  out  1  word valid.
- st_ready  in  1  sink accepts when valid && ready.
- st_sop, st_eop  out  1  first and last word of a packet.
- busy  out  1  high in any state other than IDLE.
- pkt_count  out  16  packets completed, wraps at 0xFFFF.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE. All outputs are 0; pkt_count=0. The skid buffer is emptied. A pop in flight is discarded and that entry is lost, by design.
- Packet start condition (in IDLE): fifo_count>=BURST_LEN, or (flush && fifo_count!=0).
  - Latch len = min(fifo_count, BURST_LEN).
  - Set pops_left=len and sent=0, then go to READ.
- READ:
  - fifo_rd_en = pops_left!=0 && !fifo_empty && (occ + inflight) < 2.
  - occ is skid-buffer occupancy (0..2). inflight is fifo_rd_en delayed by one cycle.
  - Each pop decrements pops_left.
  - In the cycle after a pop (inflight==1), {fifo_score,fifo_l,fifo_q,fifo_s} is written to the skid tail unconditionally.
  - Go to DRAIN when pops_left reaches 0.
- Skid buffer:
  - 2-entry FIFO; the head drives st_data.
  - st_valid = occ!=0.
  - Head pops on st_valid && st_ready.
  - Write and read in the same cycle is allowed; occ is unchanged.
- Framing:
  - st_sop = st_valid && sent==0.
  - st_eop = st_valid && sent==len-1.
  - sent increments on each accepted word.
- DRAIN:
  - Wait for the word carrying eop to be accepted.
  - On acceptance: pkt_count+1, then go to IDLE.
  - A new packet cannot start in the same cycle; at least 1 idle cycle is required.
- Throughput: with st_ready held high, 1 word per cycle after a 2-cycle latency (pop, then capture, then valid).
- Backpressure: st_ready low freezes data, sop and eop. No pops are issued while occ+inflight==2.
- Unexpected fifo_empty mid-packet: the pop is stalled (no underflow pop) and packet length is preserved.
- flush sampled while not in IDLE: ignored.
- len==1: st_sop and st_eop assert together.

Optional Feature:
- Macro: HSP_FIFO_DRAIN_HEADER_EN.
- Defined:
  - Each packet is preceded by one header word {8'hA5, 8'h00, pkt_count[7:0], len[7:0]}. pkt_count is the value before increment.
  - The header carries st_sop. Data words then have st_sop=0, and eop is on the last data word.
  - Extra state HDR between IDLE and READ. Pops may overlap HDR backpressure, subject to the occ rule.
  - Packet is len+1 words.
- Undefined: no HDR state; packet is len words, as above.

Decomposition:
- Package hsp_pkg:
  - FIELD_W.
  - Word-field offsets (S_LSB=0, Q_LSB=8, L_LSB=16, SCORE_LSB=24).
  - State encoding IDLE/HDR/READ/DRAIN.
  - HDR_MAGIC=8'hA5.
- Sub-module hsp_skid2: 2-entry valid/ready skid buffer carrying word plus nothing else; sop/eop are derived outside.

Test Plan:
- FIFO preloaded with 8 entries, s=i, q=i+16, l=i+1, score=i+32; st_ready=1 -> one packet of 8 words. Word0=0x20010 100 (i.e. 0x20011000), sop on word0, eop on word7. Exactly 2 cycles from first pop to first valid; pkt_count=1.
- 3 entries, flush pulsed -> one packet of 3 words {sop,-,eop}. fifo_rd_en asserts exactly 3 times.
- 8 entries, st_ready toggling 1,0,0,1... -> no word lost or duplicated, data stable while stalled. fifo_rd_en never asserts while occ+inflight==2.
- 1 entry plus flush -> single word with sop=eop=1.
- rst low mid-packet after 4 accepted words -> next cycle st_valid=0, busy=0, pkt_count=0, fifo_rd_en=0. A subsequent 8-entry fill produces a clean packet.
- HSP_FIFO_DRAIN_HEADER_EN defined, 2 entries plus flush -> header 0xA5000002 with sop, then 2 data words with eop on the second.
